// File: rtl/conv_encoder_frame.sv
// conv_encoder_frame: rate-1/2, K=3 convolutional encoder (g0=7, g1=5 octal).
// Captures one FRAME_BITS-wide frame and emits one 2-bit symbol per accepted
// handshake, bit 0 of the frame first.
// Optional build macro CONV_ENC_TAIL_EN: append TAIL_BITS zero symbols so the
// trellis terminates in state 00; without it the frame ends unterminated.
module conv_encoder_frame #(
   parameter int FRAME_BITS = 62,
   parameter int TAIL_BITS  = 2,
   parameter int CNT_W      = 7
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [FRAME_BITS-1:0] data_in,
   input  logic                  valid_input,
   output logic                  ready_input,
   output logic [1:0]            data_out,
   output logic                  valid_output,
   input  logic                  out_ready,
   output logic                  last_symbol,
   output logic                  frame_done,
   output logic [CNT_W-1:0]      sym_count
);

`ifdef CONV_ENC_TAIL_EN
   localparam bit TAIL_EN = 1'b1;
   typedef enum logic [1:0] {IDLE = 2'd0, ENC = 2'd1, TAIL = 2'd2, DONE = 2'd3} state_t;
`else
   localparam bit TAIL_EN = 1'b0;
   typedef enum logic [1:0] {IDLE = 2'd0, ENC = 2'd1, DONE = 2'd3} state_t;
`endif

   localparam int              NSYM          = FRAME_BITS + (TAIL_EN ? TAIL_BITS : 0);
   localparam logic [CNT_W-1:0] LAST_IDX      = CNT_W'(NSYM - 1);
   localparam logic [CNT_W-1:0] DATA_LAST_IDX = CNT_W'(FRAME_BITS - 1);

   state_t                  state_reg, state_next;
   logic [FRAME_BITS-1:0]   frame_reg, frame_next;
   logic [1:0]              shift_reg, shift_next;      // {s1, s0}
   logic [CNT_W-1:0]        sym_count_reg, count_next;
   logic [1:0]              data_out_reg, data_out_next;
   logic                    valid_reg, valid_next;
   logic                    last_reg, last_next;

   logic [2**CNT_W-1:0]     bit_seq;    // frame bits followed by zero flush bits
   logic [CNT_W-1:0]        count_inc;
   logic                    u_cur, u_nxt;
   logic [1:0]              shift_adv;

   // Input bit sequence indexed by symbol number; positions past the frame are 0.
   genvar gi;
   generate
      for (gi = 0; gi < 2**CNT_W; gi++) begin : g_seq
         if (gi < FRAME_BITS) begin : g_data
            assign bit_seq[gi] = frame_reg[gi];
         end else begin : g_zero
            assign bit_seq[gi] = 1'b0;
         end
      end
   endgenerate

   // Next-state logic; the symbol for the next index is precomputed so data_out stays registered.
   always_comb begin
      state_next    = state_reg;
      frame_next    = frame_reg;
      shift_next    = shift_reg;
      count_next    = sym_count_reg;
      data_out_next = data_out_reg;
      valid_next    = valid_reg;
      last_next     = last_reg;
      count_inc     = sym_count_reg + CNT_W'(1);
      u_cur         = bit_seq[sym_count_reg];
      u_nxt         = bit_seq[count_inc];
      shift_adv     = {shift_reg[0], u_cur};

      case (state_reg)
         IDLE: begin
            if (valid_input) begin
               frame_next    = data_in;
               shift_next    = 2'b00;
               count_next    = '0;
               // With a zero state both generators reduce to the input bit.
               data_out_next = {data_in[0], data_in[0]};
               valid_next    = 1'b1;
               last_next     = (LAST_IDX == '0);
               state_next    = ENC;
            end
         end
`ifdef CONV_ENC_TAIL_EN
         ENC, TAIL: begin
`else
         ENC: begin
`endif
            if (valid_reg && out_ready) begin
               shift_next = shift_adv;
               if (sym_count_reg == LAST_IDX) begin
                  // Final symbol accepted: count stays at NSYM-1, outputs go quiet.
                  valid_next    = 1'b0;
                  last_next     = 1'b0;
                  data_out_next = 2'b00;
                  state_next    = DONE;
               end else begin
                  count_next    = count_inc;
                  data_out_next = {u_nxt ^ shift_adv[1], u_nxt ^ shift_adv[0] ^ shift_adv[1]};
                  last_next     = (count_inc == LAST_IDX);
`ifdef CONV_ENC_TAIL_EN
                  if (sym_count_reg == DATA_LAST_IDX) begin
                     state_next = TAIL;
                  end
`endif
               end
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and output registers with asynchronous abort.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         frame_reg     <= '0;
         shift_reg     <= 2'b00;
         sym_count_reg <= '0;
         data_out_reg  <= 2'b00;
         valid_reg     <= 1'b0;
         last_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         frame_reg     <= frame_next;
         shift_reg     <= shift_next;
         sym_count_reg <= count_next;
         data_out_reg  <= data_out_next;
         valid_reg     <= valid_next;
         last_reg      <= last_next;
      end
   end

   assign ready_input  = (state_reg == IDLE);
   assign frame_done   = (state_reg == DONE);
   assign data_out     = data_out_reg;
   assign valid_output = valid_reg;
   assign last_symbol  = last_reg;
   assign sym_count    = sym_count_reg;

endmodule

// File: doc/conv_encoder_frame.md
Name: conv_encoder_frame

Overview:
- Rate-1/2, constraint-length-3 convolutional encoder; the transmit-side counterpart of the team's 4-state Viterbi decoder.
- Accepts one parallel frame of FRAME_BITS information bits and serialises it into 2-bit coded symbols, one symbol per accepted handshake.
- Appends K-1 zero tail bits so the trellis terminates in state 0, which matches the decoder's zero-start assumption.
- Sits between the frame source and the channel/decoder symbol interface.

Parameters:
- FRAME_BITS, 62, number of information bits per frame.
- TAIL_BITS, 2, number of zero flush bits (K-1); used only when the tail is enabled.
- CNT_W, 7, width of the symbol counter; must satisfy 2^CNT_W > FRAME_BITS+TAIL_BITS.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  FRAME_BITS  frame to encode; bit 0 is transmitted first.
- valid_input  in  1  frame-load request; sampled only while ready_input=1.
- ready_input  out  1  high in IDLE (encoder can accept a frame).
- data_out  out  2  coded symbol; data_out[0]=g0 (octal 7), data_out[1]=g1 (octal 5).
- valid_output  out  1  data_out holds a valid symbol.
- out_ready  in  1  downstream accepts the symbol this cycle.
- last_symbol  out  1  high together with valid_output on the final symbol of the frame.
- frame_done  out  1  one-cycle pulse after the final symbol is accepted.
- sym_count  out  CNT_W  index of the symbol currently presented (debug).

Behaviour:
- Reset (asynchronous):
  - state=IDLE; shift register {s1,s0}=00; frame register=0; sym_count=0.
  - data_out=00; valid_output=0; last_symbol=0; frame_done=0; ready_input=1.
- Encoder math, for input bit u and current state {s1,s0}:
  - data_out[0] = u^s0^s1.
  - data_out[1] = u^s1.
  - State update on symbol acceptance: s1<=s0, s0<=u.
- Symbol transfer: a symbol is transferred on a rising edge where valid_output && out_ready.
- Number of symbols per frame: NSYM = FRAME_BITS+TAIL_BITS with the tail enabled, FRAME_BITS without it.
- State machine:
  - IDLE: ready_input=1. If valid_input=1, capture data_in, clear {s1,s0} to 00, clear sym_count, go to ENC. Latency: the first symbol is valid on the cycle after capture.
  - ENC: ready_input=0; valid_output=1; u=frame[sym_count].
    - On transfer: increment sym_count and update the state.
    - If sym_count==FRAME_BITS-1 at transfer: go to TAIL when the tail is enabled, else DONE.
  - TAIL: u=0; valid_output=1. On transfer with sym_count==NSYM-1, go to DONE; otherwise increment sym_count.
  - DONE: valid_output=0; frame_done=1 for exactly one cycle; next state IDLE.
- Output registration: data_out, valid_output and last_symbol are registered and change only after a transfer or a state change.
- Backpressure: while out_ready=0, data_out, last_symbol, sym_count and {s1,s0} hold their values.
- Boundaries:
  - valid_input outside IDLE is ignored; the frame is not re-captured.
  - valid_input in the same cycle frame_done pulses is ignored; a new frame is accepted on the cycle after.
  - The frame is captured once; data_in may change freely after capture.
  - Reset asserted mid-frame aborts immediately and returns all outputs to their reset values; no frame_done is issued.
  - sym_count never exceeds NSYM-1 and never wraps.

Optional Feature:
- Macro: CONV_ENC_TAIL_EN.
- Defined: TAIL_BITS zero symbols are appended after the data symbols. NSYM=64 at the default parameters; the encoder ends in state 00.
- Undefined: no TAIL state. NSYM=FRAME_BITS; last_symbol is asserted on symbol FRAME_BITS-1, and the final encoder state is left unterminated.

Test Plan:
- Reset/idle: hold reset 3 cycles, then release -> valid_output=0, ready_input=1, data_out=00, frame_done=0.
- All-zero frame (tail enabled), out_ready=1 -> 64 consecutive symbols of 00, last_symbol set on symbol 63, frame_done pulses one cycle later, ready_input returns to 1.
- Impulse: data_in bit0=1, all other bits 0 -> symbols 11, 01, 11, then 00 for every remaining symbol; total 64 symbols.
- Backpressure: all-ones frame with out_ready toggling 1,0,0,1 -> data_out/sym_count frozen while out_ready=0. Sequence: 11, 10, 01, 01 … (steady state 01), tail symbols 10, 11. No symbol lost or duplicated.
- Ignored load and reset abort: pulse valid_input with a new frame at symbol 10 -> no effect. Then assert reset at symbol 20 -> valid_output=0 immediately, no frame_done, and the next frame starts again at sym_count=0.
- Tail disabled (build without CONV_ENC_TAIL_EN): impulse frame -> exactly 62 symbols, last_symbol on symbol 61, frame_done one cycle after symbol 61 is accepted.
